// File: rtl/fxp_div_pkg.sv
// Shared types and helpers for the signed fixed-point sequential divider.
// Holds the FSM state enum, the shift length helper and the saturation limits.
package fxp_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        FINISH,
        HOLD
    } state_t;

    typedef struct packed {
        logic [31:0] pos;     // largest positive value, 2^(w-1)-1
        logic [31:0] neg_mag; // magnitude of most negative value, 2^(w-1)
    } sat_lim_t;

    // Number of restoring iterations: dividend bits plus the FRAC pre-shift.
    function automatic int calc_n(input int w, input int f);
        return w + f;
    endfunction

    function automatic sat_lim_t sat_lim(input int w);
        sat_lim_t l;
        l.neg_mag = 32'h1 << (w - 1);
        l.pos     = l.neg_mag - 32'h1;
        return l;
    endfunction

endpackage

// File: rtl/fxp_signed_div_seq_if.sv
// Operand/result handshake bundle for fxp_signed_div_seq.
// master: drives operands and result-ready; slave: the divider.
interface fxp_signed_div_seq_if #(
    parameter int WIDTH = 8
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_dividend;
    logic [WIDTH-1:0] i_divisor;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_quotient;
    logic             o_ovf;
    logic             o_dbz;

    modport master (
        output i_valid, i_dividend, i_divisor, i_ready,
        input  o_ready, o_valid, o_quotient, o_ovf, o_dbz
    );

    modport slave (
        input  i_valid, i_dividend, i_divisor, i_ready,
        output o_ready, o_valid, o_quotient, o_ovf, o_dbz
    );
endinterface

// File: rtl/fxp_div_step.sv
// One combinational restoring-division iteration.
// rem_i/bit_i/dvs_i in; rem_o (next remainder) and q_o (quotient bit) out.
module fxp_div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);
    logic [WIDTH+1:0] sh;
    logic [WIDTH:0]   diff;

    // rem stays below the divisor, so the top bit of sh is always zero
    // and the difference fits in WIDTH+1 bits.
    assign sh    = {rem_i, bit_i};
    assign q_o   = (sh >= {2'b00, dvs_i});
    assign diff  = sh[WIDTH:0] - {1'b0, dvs_i};
    assign rem_o = q_o ? diff : sh[WIDTH:0];
endmodule

// File: rtl/fxp_signed_div_seq.sv
// Handshaked signed fixed-point divider: (dividend << FRAC) / divisor.
// Ports: i_clk, i_reset (sync, active high), bus (slave side of the handshake).
module fxp_signed_div_seq
    import fxp_div_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int FRAC  = 4
) (
    input logic                 i_clk,
    input logic                 i_reset,
    fxp_signed_div_seq_if.slave bus
);
    localparam int       N   = calc_n(WIDTH, FRAC);
    localparam int       CW  = $clog2(N);
    localparam sat_lim_t LIM = sat_lim(WIDTH);
    localparam logic [WIDTH-1:0] MAXP = WIDTH'(LIM.pos);
    localparam logic [WIDTH-1:0] MINN = WIDTH'(LIM.neg_mag);

    state_t           state_q, state_d;
    logic             sign_q, sign_d;
    logic             dneg_q, dneg_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [N-1:0]     shreg_q, shreg_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic             ovf_q, ovf_d;
    logic             odbz_q, odbz_d;

    logic [WIDTH:0]   step_rem;
    logic             step_q;
    logic [WIDTH-1:0] amag;

    fxp_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .bit_i (shreg_q[N-1]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // |min-neg| wraps to itself, which is the correct unsigned magnitude.
    assign amag = bus.i_dividend[WIDTH-1] ? -bus.i_dividend : bus.i_dividend;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            dneg_q  <= 1'b0;
            dbz_q   <= 1'b0;
            dvs_q   <= '0;
            shreg_q <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            quot_q  <= '0;
            ovf_q   <= 1'b0;
            odbz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            dneg_q  <= dneg_d;
            dbz_q   <= dbz_d;
            dvs_q   <= dvs_d;
            shreg_q <= shreg_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            quot_q  <= quot_d;
            ovf_q   <= ovf_d;
            odbz_q  <= odbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        dneg_d  = dneg_q;
        dbz_d   = dbz_q;
        dvs_d   = dvs_q;
        shreg_d = shreg_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        quot_d  = quot_q;
        ovf_d   = ovf_q;
        odbz_d  = odbz_q;
        unique case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    sign_d  = bus.i_dividend[WIDTH-1]
                            ^ bus.i_divisor[WIDTH-1];
                    dneg_d  = bus.i_dividend[WIDTH-1];
                    dbz_d   = (bus.i_divisor == '0);
                    dvs_d   = bus.i_divisor[WIDTH-1] ? -bus.i_divisor
                                                     : bus.i_divisor;
                    shreg_d = N'(amag) << FRAC;
                    rem_d   = '0;
                    cnt_d   = CW'(N - 1);
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                // Quotient bits fill in from the LSB as dividend bits leave.
                rem_d   = step_rem;
                shreg_d = {shreg_q[N-2:0], step_q};
                if (cnt_q == '0) begin
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FINISH: begin
                ovf_d  = 1'b0;
                odbz_d = 1'b0;
                if (dbz_q) begin
                    odbz_d = 1'b1;
                    quot_d = dneg_q ? MINN : MAXP;
                end else if (!sign_q) begin
                    if (shreg_q > N'(MAXP)) begin
                        quot_d = MAXP;
                        ovf_d  = 1'b1;
                    end else begin
                        quot_d = shreg_q[WIDTH-1:0];
                    end
                end else begin
                    if (shreg_q > N'(MINN)) begin
                        quot_d = MINN;
                        ovf_d  = 1'b1;
                    end else begin
                        quot_d = -shreg_q[WIDTH-1:0];
                    end
                end
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (bus.i_ready) begin
                    valid_d = 1'b0;
                    ovf_d   = 1'b0;
                    odbz_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.o_ready    = (state_q == IDLE);
    assign bus.o_valid    = valid_q;
    assign bus.o_quotient = quot_q;
    assign bus.o_ovf      = ovf_q;
    assign bus.o_dbz      = odbz_q;
endmodule
